// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch history table with 2-bit saturating counters,
// execute-stage outcome decode, mispredict detection and statistics counters.
module branch_predictor #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned LINES    = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [PC_WIDTH-1:0] guess_pc,
    input  logic                guess_valid,
    output logic                guess_taken,

    input  logic [PC_WIDTH-1:0] check_pc,
    input  logic                check_valid,
    input  logic [2:0]          check_funct3,
    input  logic                check_br_eq,
    input  logic                check_br_lt,
    input  logic                check_guess,
    output logic                br_taken,
    output logic                mispredict,

    input  logic                stats_clr,
    output logic [31:0]         branch_cnt,
    output logic [31:0]         mispredict_cnt
);

    localparam int unsigned IDX   = $clog2(LINES);
    localparam int unsigned TAG_W = PC_WIDTH - 2 - IDX;
    localparam int unsigned CNT_W = 32;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [LINES];
    logic [TAG_W-1:0] tag_d [LINES];
    logic [1:0]       ctr_q [LINES];
    logic [1:0]       ctr_d [LINES];

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic [IDX-1:0]   g_idx;
    logic [TAG_W-1:0] g_tag;
    logic [IDX-1:0]   c_idx;
    logic [TAG_W-1:0] c_tag;
    logic             c_hit;
    logic             c_legal;
    logic             c_taken;
    logic             unused_pc_bits;

    assign g_idx = guess_pc[2 +: IDX];
    assign g_tag = guess_pc[PC_WIDTH-1 -: TAG_W];
    assign c_idx = check_pc[2 +: IDX];
    assign c_tag = check_pc[PC_WIDTH-1 -: TAG_W];

    // Word-aligned PCs: the byte-offset bits carry no information here.
    assign unused_pc_bits = ^{guess_pc[1:0], check_pc[1:0]};

    // Fetch lookup; a miss predicts not-taken.
    always_comb begin
        guess_taken = 1'b0;
        if (guess_valid && valid_q[g_idx] && (tag_q[g_idx] == g_tag)) begin
            guess_taken = ctr_q[g_idx][1];
        end
    end

    // Outcome decode from comparator flags.
    always_comb begin
        c_legal = 1'b0;
        c_taken = 1'b0;
        if (check_valid) begin
            unique case (check_funct3)
                F3_BEQ:  begin c_legal = 1'b1; c_taken = check_br_eq;  end
                F3_BNE:  begin c_legal = 1'b1; c_taken = !check_br_eq; end
                F3_BLT:  begin c_legal = 1'b1; c_taken = check_br_lt;  end
                F3_BGE:  begin c_legal = 1'b1; c_taken = !check_br_lt; end
                F3_BLTU: begin c_legal = 1'b1; c_taken = check_br_lt;  end
                F3_BGEU: begin c_legal = 1'b1; c_taken = !check_br_lt; end
                default: begin c_legal = 1'b0; c_taken = 1'b0;         end
            endcase
        end
    end

    assign br_taken   = c_legal & c_taken;
    assign mispredict = c_legal & (br_taken != check_guess);
    assign c_hit      = valid_q[c_idx] && (tag_q[c_idx] == c_tag);

    // Table training: single write port, driven by the execute-stage check.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        ctr_d   = ctr_q;
        if (c_legal) begin
            if (c_hit) begin
                if (c_taken && (ctr_q[c_idx] != CTR_ST)) begin
                    ctr_d[c_idx] = ctr_q[c_idx] + 2'(1);
                end else if (!c_taken && (ctr_q[c_idx] != CTR_SNT)) begin
                    ctr_d[c_idx] = ctr_q[c_idx] - 2'(1);
                end
            end else if (c_taken) begin
                valid_d[c_idx] = 1'b1;
                tag_d[c_idx]   = c_tag;
                ctr_d[c_idx]   = CTR_WT;
            end
        end
    end

    // Statistics; clear wins over a same-cycle increment.
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (stats_clr) begin
            branch_cnt_d     = '0;
            mispredict_cnt_d = '0;
        end else if (c_legal) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
            if (mispredict) begin
                mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(LINES); i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            ctr_q   <= ctr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule
